// File: rtl/pc_gen_if.sv
// Fetch-PC generator interface: redirect/exception requests in, fetch address and status out.
// master = pc_gen, slave = the pipeline driving the requests and consuming pcF.
interface pc_gen_if;
    logic        stallF;
    logic        validD;
    logic        branch_takeD;
    logic [31:0] branch_targetD;
    logic        jumpD;
    logic [31:0] jump_targetD;
    logic        exceptionM;
    logic [31:0] exception_pcM;
    logic [31:0] pcF;
    logic [31:0] pc_plus4F;
    logic        redirect_pendingF;
    logic        adelF;

    modport master (
        input  stallF, validD, branch_takeD, branch_targetD,
        input  jumpD, jump_targetD, exceptionM, exception_pcM,
        output pcF, pc_plus4F, redirect_pendingF, adelF
    );

    modport slave (
        output stallF, validD, branch_takeD, branch_targetD,
        output jumpD, jump_targetD, exceptionM, exception_pcM,
        input  pcF, pc_plus4F, redirect_pendingF, adelF
    );
endinterface

// File: rtl/pc_gen.sv
// Fetch PC generator with delay-slot aware branch/jump redirect and exception flush.
// Optional macro PC_ALIGN_CHECK_EN enables the misaligned-fetch flag adelF.
//
// state   | meaning
// IDLE    | sequential fetch or immediate redirect
// PENDING | redirect captured in pend_pc, waiting for the delay-slot fetch (stallF=0)
module pc_gen (
    input  logic      clk,
    input  logic      rst,
    pc_gen_if.master  pc
);
    localparam logic [31:0] RESET_PC = 32'hBFC0_0000;

    typedef enum logic {IDLE = 1'b0, PENDING = 1'b1} state_t;

    state_t      state, state_nxt;
    logic [31:0] pc_q, pc_nxt;
    logic [31:0] pend_pc, pend_nxt;
    logic        redir;
    logic [31:0] target;

    assign redir  = pc.validD & (pc.jumpD | pc.branch_takeD);
    assign target = pc.jumpD ? pc.jump_targetD : pc.branch_targetD;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            pc_q    <= RESET_PC;
            pend_pc <= 32'h0;
        end else begin
            state   <= state_nxt;
            pc_q    <= pc_nxt;
            pend_pc <= pend_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        pc_nxt    = pc_q;
        pend_nxt  = pend_pc;
        if (pc.exceptionM) begin
            // Flush wins over everything, including a captured redirect.
            state_nxt = IDLE;
            pc_nxt    = pc.exception_pcM;
            pend_nxt  = 32'h0;
        end else begin
            case (state)
                IDLE: begin
                    if (redir && pc.stallF) begin
                        state_nxt = PENDING;
                        pend_nxt  = target;
                    end else if (redir) begin
                        pc_nxt = target;
                    end else if (!pc.stallF) begin
                        pc_nxt = pc_q + 32'd4;
                    end
                end
                PENDING: begin
                    // ID is stalled behind IF here, so any redir it shows is stale.
                    if (!pc.stallF) begin
                        state_nxt = IDLE;
                        pc_nxt    = pend_pc;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_comb begin
        pc.pcF               = pc_q;
        pc.pc_plus4F         = pc_q + 32'd4;
        pc.redirect_pendingF = (state == PENDING);
    end

`ifdef PC_ALIGN_CHECK_EN
    assign pc.adelF = (pc_q[1:0] != 2'b00);
`else
    assign pc.adelF = 1'b0;
`endif

endmodule

// File: tb/tb_pc_gen.sv
// Directed self-checking bench for pc_gen: sequential fetch, redirects, exceptions, wrap, reset.
module tb_pc_gen;
    logic clk = 1'b0;
    logic rst;
    int   n_chk = 0;
    int   n_err = 0;

`ifdef PC_ALIGN_CHECK_EN
    localparam logic ALIGN_EN = 1'b1;
`else
    localparam logic ALIGN_EN = 1'b0;
`endif

    pc_gen_if pif ();

    pc_gen dut (
        .clk (clk),
        .rst (rst),
        .pc  (pif)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_chk++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h", tag, obs, exp_v);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic bt, input logic [31:0] btgt,
                         input logic j, input logic [31:0] jtgt, input logic s);
        pif.validD         = v;
        pif.branch_takeD   = bt;
        pif.branch_targetD = btgt;
        pif.jumpD          = j;
        pif.jump_targetD   = jtgt;
        pif.stallF         = s;
    endtask

    task automatic exc(input logic e, input logic [31:0] epc);
        pif.exceptionM    = e;
        pif.exception_pcM = epc;
    endtask

    initial begin
        rst = 1'b1;
        drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        exc(1'b0, 32'h0);
        #2;
        chk("rst_pc", pif.pcF, 32'hBFC0_0000);
        chk("rst_plus4", pif.pc_plus4F, 32'hBFC0_0004);
        chk("rst_pend", {31'b0, pif.redirect_pendingF}, 32'h0);
        chk("rst_adel", {31'b0, pif.adelF}, 32'h0);
        step();
        rst = 1'b0;

        // Sequential fetch
        step(); chk("seq1", pif.pcF, 32'hBFC0_0004);
        step(); chk("seq2", pif.pcF, 32'hBFC0_0008);
        step(); chk("seq3", pif.pcF, 32'hBFC0_000C);
        step(); chk("seq4", pif.pcF, 32'hBFC0_0010);

        // Unstalled taken branch
        drive(1'b1, 1'b1, 32'hBFC0_0100, 1'b0, 32'h0, 1'b0);
        step();
        chk("br_pc", pif.pcF, 32'hBFC0_0100);
        chk("br_pend", {31'b0, pif.redirect_pendingF}, 32'h0);

        // Plain stall holds pcF
        drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        step(); chk("stall_hold", pif.pcF, 32'hBFC0_0100);

        // Exception from IDLE back to BFC00010
        drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        exc(1'b1, 32'hBFC0_0010);
        step(); chk("exc_idle", pif.pcF, 32'hBFC0_0010);
        exc(1'b0, 32'h0);

        // Stalled branch: held 3 cycles, new redirects ignored while pending
        drive(1'b1, 1'b1, 32'hBFC0_0100, 1'b0, 32'h0, 1'b1);
        step();
        chk("pend1_pc", pif.pcF, 32'hBFC0_0010);
        chk("pend1_rp", {31'b0, pif.redirect_pendingF}, 32'h1);
        drive(1'b1, 1'b0, 32'h0, 1'b1, 32'hBFC0_0300, 1'b1);
        step();
        chk("pend2_pc", pif.pcF, 32'hBFC0_0010);
        chk("pend2_rp", {31'b0, pif.redirect_pendingF}, 32'h1);
        step();
        chk("pend3_pc", pif.pcF, 32'hBFC0_0010);
        chk("pend3_rp", {31'b0, pif.redirect_pendingF}, 32'h1);
        drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        step();
        chk("pend_rel_pc", pif.pcF, 32'hBFC0_0100);
        chk("pend_rel_rp", {31'b0, pif.redirect_pendingF}, 32'h0);
        step(); chk("post_pend", pif.pcF, 32'hBFC0_0104);

        // Exception during PENDING discards pend_pc
        drive(1'b1, 1'b1, 32'hBFC0_0100, 1'b0, 32'h0, 1'b1);
        step();
        chk("pend_b_rp", {31'b0, pif.redirect_pendingF}, 32'h1);
        drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        exc(1'b1, 32'hBFC0_0380);
        step();
        chk("exc_pend_pc", pif.pcF, 32'hBFC0_0380);
        chk("exc_pend_rp", {31'b0, pif.redirect_pendingF}, 32'h0);
        exc(1'b0, 32'h0);
        step(); chk("exc_hold", pif.pcF, 32'hBFC0_0380);
        drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        step(); chk("exc_next", pif.pcF, 32'hBFC0_0384);

        // Jump priority over branch
        drive(1'b1, 1'b1, 32'hBFC0_0200, 1'b1, 32'h8000_0000, 1'b0);
        step(); chk("jmp_prio", pif.pcF, 32'h8000_0000);
        // jumpD without validD is not a redirect
        drive(1'b0, 1'b0, 32'h0, 1'b1, 32'h9000_0000, 1'b0);
        step(); chk("jmp_novalid", pif.pcF, 32'h8000_0004);

        // 32-bit wrap
        drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        exc(1'b1, 32'hFFFF_FFFC);
        step();
        exc(1'b0, 32'h0);
        chk("wrap_pc", pif.pcF, 32'hFFFF_FFFC);
        chk("wrap_plus4", pif.pc_plus4F, 32'h0000_0000);
        step(); chk("wrap_next", pif.pcF, 32'h0000_0000);

        // Misaligned jump target
        drive(1'b1, 1'b0, 32'h0, 1'b1, 32'h8000_0002, 1'b0);
        step();
        chk("mis_pc", pif.pcF, 32'h8000_0002);
        chk("mis_adel", {31'b0, pif.adelF}, {31'b0, ALIGN_EN});
        drive(1'b1, 1'b1, 32'h8000_0010, 1'b0, 32'h0, 1'b0);
        step();
        chk("al_adel", {31'b0, pif.adelF}, 32'h0);

        // Reset while PENDING
        drive(1'b1, 1'b1, 32'hBFC0_0500, 1'b0, 32'h0, 1'b1);
        step();
        chk("pend_c_rp", {31'b0, pif.redirect_pendingF}, 32'h1);
        #2 rst = 1'b1;
        #1;
        chk("arst_pc", pif.pcF, 32'hBFC0_0000);
        chk("arst_rp", {31'b0, pif.redirect_pendingF}, 32'h0);
        drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        step();
        chk("arst_hold", pif.pcF, 32'hBFC0_0000);
        rst = 1'b0;
        step(); chk("arst_next", pif.pcF, 32'hBFC0_0004);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/pc_gen.md
PC_GEN -- requirements
Module: pc_gen

Interface
REQ-001 clk  input  1  core clock; all state updates on rising edge.
REQ-002 rst  input  1  asynchronous, active-high reset.
REQ-003 stallF  input  1  IF hold; 1 = current fetch at pcF not complete.
REQ-004 validD  input  1  ID holds a valid, non-stalled instruction this cycle.
REQ-005 branch_takeD  input  1  taken-branch result from the ID compare unit.
REQ-006 branch_targetD  input  32  branch target (PC of branch + 4 + sign-extended offset << 2).
REQ-007 jumpD  input  1  j/jal/jr/jalr in ID.
REQ-008 jump_targetD  input  32  resolved jump target.
REQ-009 exceptionM  input  1  exception or eret committed in MEM; flush request.
REQ-010 exception_pcM  input  32  handler vector or EPC.
REQ-011 pcF  output  32  fetch address, registered.
REQ-012 pc_plus4F  output  32  pcF + 4, combinational.
REQ-013 redirect_pendingF  output  1  1 while a captured redirect waits for stallF to drop.
REQ-014 adelF  output  1  fetch address misaligned; see Configuration.

Function
REQ-015 Redirect request: redir = validD & (jumpD | branch_takeD); target = jumpD ? jump_targetD : branch_targetD (jumpD has priority when both are set).
REQ-016 The instruction at pcF when redir is seen is the delay slot; pcF moves to target only once that fetch completes (stallF=0).
REQ-017 States: IDLE, PENDING; reset state IDLE.
REQ-018 IDLE, no exceptionM, redir=1, stallF=0: pcF <= target next cycle; stay IDLE.
REQ-019 IDLE, no exceptionM, redir=1, stallF=1: capture target into pend_pc; go PENDING; pcF unchanged.
REQ-020 IDLE, no redir, no exceptionM: pcF <= stallF ? pcF : pcF + 4.
REQ-021 PENDING, stallF=1: hold pcF and pend_pc; any new redir is ignored, because ID is stalled behind IF.
REQ-022 PENDING, stallF=0: pcF <= pend_pc; go IDLE.
REQ-023 exceptionM=1 has highest priority in any state, regardless of stallF: pcF <= exception_pcM next cycle; state <= IDLE; pend_pc discarded.
REQ-024 redirect_pendingF = (state == PENDING), registered.
REQ-025 Arithmetic is 32-bit unsigned; pcF + 4 wraps 32'hFFFF_FFFC -> 32'h0000_0000 with no flag.
REQ-026 Latency: a redirect or exception seen in cycle N appears on pcF in cycle N+1 at the earliest.

Reset
REQ-027 On rst assertion, asynchronously: pcF = 32'hBFC0_0000, state = IDLE, pend_pc = 0, redirect_pendingF = 0, adelF = 0.
REQ-028 Reset mid-PENDING discards the captured target; first post-reset fetch is 32'hBFC0_0000.
REQ-029 pc_plus4F after reset = 32'hBFC0_0004.

Configuration
REQ-030 Macro PC_ALIGN_CHECK_EN: when defined, adelF = (pcF[1:0] != 2'b00), combinational from pcF; pcF is still driven with the misaligned value so EPC/BadVAddr can capture it.
REQ-031 Without PC_ALIGN_CHECK_EN: adelF is tied to 0 and the check logic is absent.

Verification
REQ-032 Reset release, stallF=0 for 3 cycles -> pcF = BFC00000, BFC00004, BFC00008, BFC0000C.
REQ-033 pcF=BFC00010, validD=1, branch_takeD=1, branch_targetD=BFC00100, stallF=0 -> next pcF=BFC00100; redirect_pendingF stays 0.
REQ-034 Same branch with stallF=1 for 3 cycles -> pcF held at BFC00010, redirect_pendingF=1 for 3 cycles; cycle after stallF drops -> pcF=BFC00100, redirect_pendingF=0.
REQ-035 PENDING with pend_pc=BFC00100, exceptionM=1, exception_pcM=BFC00380, stallF=1 -> next pcF=BFC00380, redirect_pendingF=0; later stallF=0 -> pcF=BFC00384, never BFC00100.
REQ-036 jumpD=1, jump_targetD=80000000, and branch_takeD=1, branch_targetD=BFC00200 together -> next pcF=80000000.
REQ-037 PC_ALIGN_CHECK_EN defined, jump_targetD=80000002 -> pcF=80000002, adelF=1; macro undefined -> adelF=0.
